// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Signed mode subtracts the multiplicand on the final (sign) bit.
module mul_seq_unit #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultLo,
  output logic [WIDTH-1:0] oResultHi,
  output logic             oOverflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   acc;
  logic             sgn;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             lastBit;
  logic [WIDTH:0]   extA;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nextLo;
  logic             ovfNext;

  always_comb begin
    accept    = iStart && (state != RUN);
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (lastBit) stateNext = DONE;
      DONE:    stateNext = accept ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // acc is one bit wider than an operand so the
  // running partial sum never wraps in either mode
  always_comb begin
    lastBit = (cnt == CW'(WIDTH - 1));
    extA    = {sgn & mcand[WIDTH-1], mcand};
    addend  = '0;
    if (mplier[0]) begin
      if (lastBit && sgn) addend = -extA;
      else                addend = extA;
    end
    sum    = acc + addend;
    nextLo = {sum[0], mplier[WIDTH-1:1]};
    if (sgn)
      ovfNext = sum[WIDTH:1] != {WIDTH{nextLo[WIDTH-1]}};
    else
      ovfNext = sum[WIDTH:1] != '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      sgn       <= 1'b0;
      cnt       <= '0;
      oResultLo <= '0;
      oResultHi <= '0;
      oOverflow <= 1'b0;
    end else if (accept) begin
      mcand  <= iA;
      mplier <= iB;
      sgn    <= iSigned;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= {sgn & sum[WIDTH], sum[WIDTH:1]};
      mplier <= nextLo;
      cnt    <= cnt + 1'b1;
      if (lastBit) begin
        oResultHi <= sum[WIDTH:1];
        oResultLo <= nextLo;
        oOverflow <= ovfNext;
      end
    end
  end

  assign oBusy = (state == RUN);
  assign oDone = (state == DONE);

endmodule
